// File: rtl/edge_decode_multi_pkg.sv
// ---------------------------------------------------------------------------
// edge_decode_multi_pkg
// Shared definitions for the delay-line edge decoder: default tap/decode
// widths and the controller state encodings.
// ---------------------------------------------------------------------------
package edge_decode_multi_pkg;

  localparam int DEF_NUM_TAPS   = 36;
  localparam int DEF_NUM_DECODE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/edge_decode_multi_match_enc.sv
// ---------------------------------------------------------------------------
// edge_match_enc
// Finds every bubble-filtered transition in a captured tap vector and
// encodes the highest position (index+1) and the number of transitions
// through PIPE_STAGES register stages.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   i_taps     captured tap vector (NUM_TAPS bits)
//   i_falling  0 = look for 1 followed by 0s, 1 = look for 0 followed by 1s
//   o_pos      highest matching index + 1, 0 when nothing matches
//   o_count    number of matching positions
// ---------------------------------------------------------------------------
module edge_match_enc
  import edge_decode_multi_pkg::*;
#(
  parameter int NUM_TAPS    = DEF_NUM_TAPS,
  parameter int FILTER_LEN  = 4,
  parameter int PIPE_STAGES = 2,
  parameter int CW          = $clog2(NUM_TAPS + 1)
)(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_TAPS-1:0] i_taps,
  input  logic                i_falling,
  output logic [CW-1:0]       o_pos,
  output logic [CW-1:0]       o_count
);

  // Positions whose full filter window still fits inside the tap vector.
  localparam int NM = NUM_TAPS - FILTER_LEN;

  logic [NUM_TAPS-1:0] w_taps;
  logic [NM-1:0]       w_match;
  logic [NM-1:0]       r_match;
  logic [CW-1:0]       w_pos;
  logic [CW-1:0]       w_cnt;

  // Falling mode is the rising search on the inverted vector.
  assign w_taps = i_falling ? ~i_taps : i_taps;

  // A match needs the tap set and the next FILTER_LEN taps all clear.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NM; i++) begin
      w_match[i] = w_taps[i] & ~(|w_taps[i+1 +: FILTER_LEN]);
    end
  end

  // First pipeline stage holds the per-position match vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_match <= '0;
    else     r_match <= w_match;
  end

  // Ascending scan: the last hit seen is the highest position.
  always_comb begin
    w_pos = '0;
    w_cnt = '0;
    for (int i = 0; i < NM; i++) begin
      if (r_match[i]) begin
        w_pos = CW'(i + 1);
        w_cnt = w_cnt + CW'(1);
      end
    end
  end

  // Remaining stages simply delay the encoded position and count.
  generate
    if (PIPE_STAGES == 1) begin : g_noPipe
      assign o_pos   = w_pos;
      assign o_count = w_cnt;
    end else begin : g_pipe
      logic [CW-1:0] r_posPipe [PIPE_STAGES-1];
      logic [CW-1:0] r_cntPipe [PIPE_STAGES-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < PIPE_STAGES - 1; k++) begin
            r_posPipe[k] <= '0;
            r_cntPipe[k] <= '0;
          end
        end else begin
          r_posPipe[0] <= w_pos;
          r_cntPipe[0] <= w_cnt;
          for (int k = 1; k < PIPE_STAGES - 1; k++) begin
            r_posPipe[k] <= r_posPipe[k-1];
            r_cntPipe[k] <= r_cntPipe[k-1];
          end
        end
      end

      assign o_pos   = r_posPipe[PIPE_STAGES-2];
      assign o_count = r_cntPipe[PIPE_STAGES-2];
    end
  endgenerate

endmodule

// File: rtl/edge_decode_multi.sv
// ---------------------------------------------------------------------------
// edge_decode_multi
// Captures a thermometer-coded delay-line sample on request and reports the
// highest bubble-filtered transition, the transition count and summary flags.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   go          one-cycle request to capture and decode taps_in
//   falling     0 = rising-edge (1 then 0s), 1 = falling-edge (0 then 1s)
//   taps_in     delay-line sample (NUM_TAPS bits)
//   busy        decode in flight
//   finished    one-cycle pulse, results valid
//   edge_pos    highest matching index + 1, 0 if none
//   edge_count  number of matches, saturating
//   no_edge     edge_count is zero
//   multi_edge  edge_count is greater than one
// ---------------------------------------------------------------------------
module edge_decode_multi
  import edge_decode_multi_pkg::*;
#(
  parameter int NUM_TAPS    = DEF_NUM_TAPS,
  parameter int NUM_DECODE  = DEF_NUM_DECODE,
  parameter int FILTER_LEN  = 4,
  parameter int PIPE_STAGES = 2
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic                  falling,
  input  logic [NUM_TAPS-1:0]   taps_in,
  output logic                  busy,
  output logic                  finished,
  output logic [NUM_DECODE-1:0] edge_pos,
  output logic [NUM_DECODE-1:0] edge_count,
  output logic                  no_edge,
  output logic                  multi_edge
);

  localparam int CW = $clog2(NUM_TAPS + 1);
  localparam int SW = (CW > NUM_DECODE) ? CW : NUM_DECODE;

  generate
    if (NUM_DECODE < $clog2(NUM_TAPS + 1)) begin : g_badDecode
      $error("edge_decode_multi: NUM_DECODE too narrow for NUM_TAPS");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > 8 || FILTER_LEN >= NUM_TAPS) begin : g_badFilter
      $error("edge_decode_multi: FILTER_LEN out of range");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_badPipe
      $error("edge_decode_multi: PIPE_STAGES out of range");
    end
  endgenerate

  state_t                r_state;
  state_t                w_nextState;
  logic [2:0]            r_stageCnt;
  logic [NUM_TAPS-1:0]   r_taps;
  logic                  r_falling;
  logic                  w_accept;
  logic [CW-1:0]         w_encPos;
  logic [CW-1:0]         w_encCount;
  logic [SW-1:0]         w_cntExt;
  logic [NUM_DECODE-1:0] w_cntSat;

  // go is honoured in IDLE and DONE only; a decode in flight cannot be disturbed.
  assign w_accept = go && (r_state != ST_RUN);
  assign busy     = (r_state == ST_RUN);

  // Next-state logic for the decode controller.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (go) w_nextState = ST_RUN;
      ST_RUN:  if (r_stageCnt == 3'(PIPE_STAGES)) w_nextState = ST_DONE;
      ST_DONE: w_nextState = go ? ST_RUN : ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State register and stage counter; the counter starts at 1 on the
  // accepting edge so DONE is reached PIPE_STAGES edges later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_stageCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept)                r_stageCnt <= 3'd1;
      else if (r_state == ST_RUN)  r_stageCnt <= r_stageCnt + 3'd1;
    end
  end

  // Input capture, frozen for the whole decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taps    <= '0;
      r_falling <= 1'b0;
    end else if (w_accept) begin
      r_taps    <= taps_in;
      r_falling <= falling;
    end
  end

  edge_match_enc #(
    .NUM_TAPS    (NUM_TAPS),
    .FILTER_LEN  (FILTER_LEN),
    .PIPE_STAGES (PIPE_STAGES),
    .CW          (CW)
  ) u_matchEnc (
    .clk       (clk),
    .rst       (rst),
    .i_taps    (r_taps),
    .i_falling (r_falling),
    .o_pos     (w_encPos),
    .o_count   (w_encCount)
  );

  assign w_cntExt = SW'(w_encCount);
  assign w_cntSat = (w_cntExt > SW'({NUM_DECODE{1'b1}})) ? '1 : w_cntExt[NUM_DECODE-1:0];

  // Results load only on the DONE edge and then hold until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      finished   <= 1'b0;
      edge_pos   <= '0;
      edge_count <= '0;
      no_edge    <= 1'b0;
      multi_edge <= 1'b0;
    end else if (r_state == ST_DONE) begin
      finished   <= 1'b1;
      edge_pos   <= NUM_DECODE'(w_encPos);
      edge_count <= w_cntSat;
      no_edge    <= (w_cntSat == '0);
      multi_edge <= (w_cntSat > NUM_DECODE'(1));
    end else begin
      finished   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_edge_decode_multi.sv
// ---------------------------------------------------------------------------
// tb_edge_decode_multi
// Directed self-checking bench for edge_decode_multi with default parameters.
// ---------------------------------------------------------------------------
module tb_edge_decode_multi;

  localparam int NT = 36;
  localparam int ND = 8;

  logic          clk;
  logic          rst;
  logic          go;
  logic          falling;
  logic [NT-1:0] taps_in;
  logic          busy;
  logic          finished;
  logic [ND-1:0] edge_pos;
  logic [ND-1:0] edge_count;
  logic          no_edge;
  logic          multi_edge;

  int errors = 0;
  int checks = 0;

  edge_decode_multi #(
    .NUM_TAPS    (NT),
    .NUM_DECODE  (ND),
    .FILTER_LEN  (4),
    .PIPE_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .falling    (falling),
    .taps_in    (taps_in),
    .busy       (busy),
    .finished   (finished),
    .edge_pos   (edge_pos),
    .edge_count (edge_count),
    .no_edge    (no_edge),
    .multi_edge (multi_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one go and count edges until finished rises (bounded at 20).
  task automatic runDecode(input logic [NT-1:0] t, input logic f, output int lat);
    taps_in = t;
    falling = f;
    go      = 1'b1;
    tick();
    go  = 1'b0;
    lat = 0;
    while (finished !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; falling = 1'b0; taps_in = '0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (finished !== 1'b0) begin errors++; $display("[TB] FAIL reset_finished: got %b expected 0", finished); end
    checks++; if (edge_pos !== 8'd0) begin errors++; $display("[TB] FAIL reset_pos: got %0d expected 0", edge_pos); end
    checks++; if (edge_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", edge_count); end
    checks++; if ({no_edge, multi_edge} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {no_edge, multi_edge}); end
    rst = 1'b0;
  endtask

  task automatic test_rising();
    int lat;
    runDecode(36'h0000000FF, 1'b0, lat);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL rising_latency: got %0d expected 3", lat); end
    checks++; if (edge_pos !== 8'd8) begin errors++; $display("[TB] FAIL rising_pos: got %0d expected 8", edge_pos); end
    checks++; if (edge_count !== 8'd1) begin errors++; $display("[TB] FAIL rising_count: got %0d expected 1", edge_count); end
    checks++; if ({no_edge, multi_edge} !== 2'b00) begin errors++; $display("[TB] FAIL rising_flags: got %b expected 00", {no_edge, multi_edge}); end
  endtask

  task automatic test_falling();
    int lat;
    runDecode(36'hFFFFFFC00, 1'b1, lat);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL falling_latency: got %0d expected 3", lat); end
    checks++; if (edge_pos !== 8'd10) begin errors++; $display("[TB] FAIL falling_pos: got %0d expected 10", edge_pos); end
    checks++; if (edge_count !== 8'd1) begin errors++; $display("[TB] FAIL falling_count: got %0d expected 1", edge_count); end
  endtask

  task automatic test_bubble();
    int lat;
    runDecode(36'h00000160F, 1'b0, lat);
    checks++; if (edge_pos !== 8'd13) begin errors++; $display("[TB] FAIL bubble_pos: got %0d expected 13", edge_pos); end
    checks++; if (edge_count !== 8'd2) begin errors++; $display("[TB] FAIL bubble_count: got %0d expected 2", edge_count); end
    checks++; if ({no_edge, multi_edge} !== 2'b01) begin errors++; $display("[TB] FAIL bubble_flags: got %b expected 01", {no_edge, multi_edge}); end
  endtask

  task automatic test_no_edge();
    int lat;
    runDecode(36'h000000000, 1'b0, lat);
    checks++; if ({edge_pos, edge_count} !== 16'd0) begin errors++; $display("[TB] FAIL zeros_result: got pos=%0d count=%0d expected 0/0", edge_pos, edge_count); end
    checks++; if ({no_edge, multi_edge} !== 2'b10) begin errors++; $display("[TB] FAIL zeros_flags: got %b expected 10", {no_edge, multi_edge}); end
    runDecode(36'hFFFFFFFFF, 1'b0, lat);
    checks++; if ({edge_pos, edge_count} !== 16'd0) begin errors++; $display("[TB] FAIL ones_result: got pos=%0d count=%0d expected 0/0", edge_pos, edge_count); end
    checks++; if ({no_edge, multi_edge} !== 2'b10) begin errors++; $display("[TB] FAIL ones_flags: got %b expected 10", {no_edge, multi_edge}); end
  endtask

  task automatic test_capture_hold();
    int lat;
    taps_in = 36'h0000000FF; falling = 1'b0; go = 1'b1;
    tick();
    go = 1'b0; taps_in = 36'h00000160F; falling = 1'b1;
    lat = 0;
    while (finished !== 1'b1 && lat < 20) begin tick(); lat++; end
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL capture_latency: got %0d expected 3", lat); end
    checks++; if ({edge_pos, edge_count} !== {8'd8, 8'd1}) begin errors++; $display("[TB] FAIL capture_result: got pos=%0d count=%0d expected 8/1", edge_pos, edge_count); end
    tick();
    checks++; if (finished !== 1'b0) begin errors++; $display("[TB] FAIL finished_width: got %b expected 0", finished); end
    taps_in = 36'h000000000;
    for (int i = 0; i < 4; i++) tick();
    checks++; if ({edge_pos, edge_count, no_edge, multi_edge} !== {8'd8, 8'd1, 2'b00}) begin errors++; $display("[TB] FAIL hold_result: got pos=%0d count=%0d flags=%b expected 8/1/00", edge_pos, edge_count, {no_edge, multi_edge}); end
    checks++; if ({busy, finished} !== 2'b00) begin errors++; $display("[TB] FAIL hold_idle: got busy/finished=%b expected 00", {busy, finished}); end
  endtask

  task automatic test_back_to_back();
    taps_in = 36'h0000000FF; falling = 1'b0; go = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy0: got %b expected 1", busy); end
    taps_in = 36'h00000160F; go = 1'b1;
    tick();
    checks++; if ({busy, finished} !== 2'b10) begin errors++; $display("[TB] FAIL b2b_busy1: got busy/finished=%b expected 10", {busy, finished}); end
    go = 1'b0;
    tick();
    checks++; if ({busy, finished} !== 2'b00) begin errors++; $display("[TB] FAIL b2b_done: got busy/finished=%b expected 00", {busy, finished}); end
    taps_in = 36'h0000F0000; go = 1'b1;
    tick();
    checks++; if ({finished, edge_pos, edge_count} !== {1'b1, 8'd8, 8'd1}) begin errors++; $display("[TB] FAIL b2b_first: got fin=%b pos=%0d count=%0d expected 1/8/1", finished, edge_pos, edge_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart: got %b expected 1", busy); end
    go = 1'b0; taps_in = 36'h000000000;
    tick();
    checks++; if (finished !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap4: got %b expected 0", finished); end
    tick();
    checks++; if (finished !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap5: got %b expected 0", finished); end
    tick();
    checks++; if ({finished, edge_pos, edge_count} !== {1'b1, 8'd20, 8'd1}) begin errors++; $display("[TB] FAIL b2b_second: got fin=%b pos=%0d count=%0d expected 1/20/1", finished, edge_pos, edge_count); end
  endtask

  task automatic test_reset_mid();
    int lat;
    taps_in = 36'h0000000FF; falling = 1'b0; go = 1'b1;
    tick();
    go = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({busy, finished, edge_pos, edge_count, no_edge, multi_edge} !== 20'd0) begin errors++; $display("[TB] FAIL midreset_async: got busy=%b fin=%b pos=%0d count=%0d flags=%b expected all 0", busy, finished, edge_pos, edge_count, {no_edge, multi_edge}); end
    tick();
    checks++; if ({busy, finished, edge_pos, edge_count, no_edge, multi_edge} !== 20'd0) begin errors++; $display("[TB] FAIL midreset_held: got busy=%b fin=%b pos=%0d count=%0d flags=%b expected all 0", busy, finished, edge_pos, edge_count, {no_edge, multi_edge}); end
    rst = 1'b0;
    runDecode(36'h00000160F, 1'b0, lat);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL postreset_latency: got %0d expected 3", lat); end
    checks++; if ({edge_pos, edge_count} !== {8'd13, 8'd2}) begin errors++; $display("[TB] FAIL postreset_result: got pos=%0d count=%0d expected 13/2", edge_pos, edge_count); end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_falling();
    test_bubble();
    test_no_edge();
    test_capture_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
